// File: rtl/spi_chain_router_pkg.sv
// Shared definitions for spi_chain_router: routing state encodings and the broadcast-address rule.
package spi_chain_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNICAST = 2'd1,
    BCAST   = 2'd2
  } routeState_t;

  // Broadcast is the all-ones address of the configured width; upper bits are ignored.
  function automatic logic isBroadcastAddr(input logic [31:0] addr, input int width);
    logic result;
    result = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i < width) && !addr[i]) result = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_chain_router_sync.sv
// spi_sync_bit: multi-flop synchroniser with asynchronous active-low clear.
// Fed a constant 1 it also serves as the reset synchroniser (async assert, sync release).
module spi_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_stages;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_chain_router.sv
// Daisy-chain SPI router: forwards the bus downstream and selects up to NUM_LOCAL local targets.
// Optional macro SPI_ROUTER_IRQ_LATCH_EN latches local interrupt edges into clearable pending bits.
module spi_chain_router
  import spi_chain_router_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int NUM_LOCAL   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 SPI_CLK,
  input  logic                 RSTin,
  input  logic                 ID_in,
  input  logic                 IRQ_in,
  input  logic                 address_strobe,
  input  logic [ADDR_W-1:0]    currentSPIAddr,
  input  logic [ADDR_W-1:0]    baseSPIAddr,
  input  logic                 irq_clear,
  input  logic                 SCLKin,
  input  logic                 SCSNin,
  input  logic                 MOSIin,
  output logic                 MISOout,
  output logic                 sclk_local,
  output logic                 scsn_local,
  output logic                 mosi_local,
  input  logic [NUM_LOCAL-1:0] miso_local,
  input  logic [NUM_LOCAL-1:0] irq_local,
  output logic [NUM_LOCAL-1:0] read_select,
  output logic [NUM_LOCAL-1:0] write_enable,
  output logic                 rst_local,
  output logic                 RSTout,
  output logic                 SCLKout,
  output logic                 SCSNout,
  output logic                 MOSIout,
  input  logic                 MISOin,
  output logic                 IRQout
);

  logic                 w_rstSynced;
  logic                 w_idActive;
  logic                 w_irqSync;
  logic                 w_scsnSync;
  logic                 w_scsnRise;
  logic [ADDR_W-1:0]    w_offset;
  logic                 w_isBcast;
  logic                 w_isHit;
  logic [NUM_LOCAL-1:0] w_hitMask;
  logic [NUM_LOCAL-1:0] w_irqSrc;

  routeState_t          r_state, w_nextState;
  logic [NUM_LOCAL-1:0] r_readSel, w_nextRead;
  logic [NUM_LOCAL-1:0] r_writeEn, w_nextWrite;
  logic                 r_scsnPrev;

  assign RSTout     = RSTin;
  assign SCLKout    = SCLKin;
  assign sclk_local = SCLKin;
  assign SCSNout    = SCSNin;
  assign scsn_local = SCSNin;
  assign MOSIout    = MOSIin;
  assign mosi_local = MOSIin;

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rstSync (
    .i_clk(SPI_CLK), .i_rst_n(RSTin), .i_d(1'b1), .o_q(w_rstSynced)
  );
  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_idSync (
    .i_clk(SPI_CLK), .i_rst_n(RSTin), .i_d(ID_in), .o_q(w_idActive)
  );
  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_irqSync (
    .i_clk(SPI_CLK), .i_rst_n(RSTin), .i_d(IRQ_in), .o_q(w_irqSync)
  );
  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_scsnSync (
    .i_clk(SPI_CLK), .i_rst_n(RSTin), .i_d(SCSNin), .o_q(w_scsnSync)
  );

  assign rst_local = ~w_rstSynced;

  // Offset wraps modulo 2^ADDR_W, so a base near the top of the space spills into low addresses.
  assign w_offset  = currentSPIAddr - baseSPIAddr;
  assign w_isBcast = isBroadcastAddr(32'(currentSPIAddr), ADDR_W);
  assign w_isHit   = !w_isBcast && (w_offset < ADDR_W'(NUM_LOCAL));
  assign w_hitMask = NUM_LOCAL'(1) << w_offset;
  assign w_scsnRise = w_scsnSync & ~r_scsnPrev;

  always_ff @(posedge SPI_CLK or negedge RSTin) begin
    if (!RSTin) begin
      r_state    <= IDLE;
      r_readSel  <= '0;
      r_writeEn  <= '0;
      r_scsnPrev <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_readSel  <= w_nextRead;
      r_writeEn  <= w_nextWrite;
      r_scsnPrev <= w_scsnSync;
    end
  end

  // A strobe takes priority over a chip-select release seen in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_nextRead  = r_readSel;
    w_nextWrite = r_writeEn;
    if (address_strobe) begin
      if (w_idActive && w_isHit) begin
        w_nextState = UNICAST;
        w_nextRead  = w_hitMask;
        w_nextWrite = w_hitMask;
      end else if (w_idActive && w_isBcast) begin
        w_nextState = BCAST;
        w_nextRead  = '0;
        w_nextWrite = {NUM_LOCAL{1'b1}};
      end else begin
        w_nextState = IDLE;
        w_nextRead  = '0;
        w_nextWrite = '0;
      end
    end else if (w_scsnRise) begin
      w_nextState = IDLE;
      w_nextRead  = '0;
      w_nextWrite = '0;
    end
  end

  assign read_select  = r_readSel;
  assign write_enable = r_writeEn;

  always_comb begin
    MISOout = MISOin;
    if (|r_readSel) MISOout = |(miso_local & r_readSel);
  end

`ifdef SPI_ROUTER_IRQ_LATCH_EN
  logic [NUM_LOCAL-1:0] r_irqPrev;
  logic [NUM_LOCAL-1:0] r_pending;

  // A fresh rising edge overrides a clear landing in the same cycle.
  always_ff @(posedge SPI_CLK or negedge RSTin) begin
    if (!RSTin) begin
      r_irqPrev <= '0;
      r_pending <= '0;
    end else begin
      r_irqPrev <= irq_local;
      r_pending <= (r_pending & ~(r_writeEn & {NUM_LOCAL{irq_clear}}))
                 | (irq_local & ~r_irqPrev);
    end
  end

  assign w_irqSrc = r_pending;
`else
  logic w_unusedIrqClear;
  assign w_unusedIrqClear = irq_clear;
  assign w_irqSrc = irq_local;
`endif

  assign IRQout = w_irqSync | (|w_irqSrc);

endmodule

// File: tb/tb_spi_chain_router.sv
// Self-checking bench for spi_chain_router (ADDR_W=7, NUM_LOCAL=4); latch checks run when
// SPI_ROUTER_IRQ_LATCH_EN is defined.
module tb_spi_chain_router;

  logic       SPI_CLK = 1'b0;
  logic       RSTin = 1'b1;
  logic       ID_in = 1'b0;
  logic       IRQ_in = 1'b0;
  logic       address_strobe = 1'b0;
  logic [6:0] currentSPIAddr = '0;
  logic [6:0] baseSPIAddr = 7'h10;
  logic       irq_clear = 1'b0;
  logic       SCLKin = 1'b0, SCSNin = 1'b0, MOSIin = 1'b0;
  logic       MISOout, sclk_local, scsn_local, mosi_local;
  logic [3:0] miso_local = '0;
  logic [3:0] irq_local = '0;
  logic [3:0] read_select, write_enable;
  logic       rst_local, RSTout, SCLKout, SCSNout, MOSIout;
  logic       MISOin = 1'b0;
  logic       IRQout;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [6:0] base;
    logic [6:0] addr;
    logic       idIn;
    logic [3:0] expRead;
    logic [3:0] expWrite;
  } vec_t;

  typedef struct {
    logic [3:0] rs;
    logic [3:0] we;
  } exp_t;

  vec_t vecs[13];
  exp_t sbQ[$];

  spi_chain_router #(.ADDR_W(7), .NUM_LOCAL(4), .SYNC_STAGES(2)) dut (
    .SPI_CLK(SPI_CLK), .RSTin(RSTin), .ID_in(ID_in), .IRQ_in(IRQ_in),
    .address_strobe(address_strobe), .currentSPIAddr(currentSPIAddr),
    .baseSPIAddr(baseSPIAddr), .irq_clear(irq_clear),
    .SCLKin(SCLKin), .SCSNin(SCSNin), .MOSIin(MOSIin), .MISOout(MISOout),
    .sclk_local(sclk_local), .scsn_local(scsn_local), .mosi_local(mosi_local),
    .miso_local(miso_local), .irq_local(irq_local),
    .read_select(read_select), .write_enable(write_enable), .rst_local(rst_local),
    .RSTout(RSTout), .SCLKout(SCLKout), .SCSNout(SCSNout), .MOSIout(MOSIout),
    .MISOin(MISOin), .IRQout(IRQout)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  task automatic tick();
    @(posedge SPI_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one strobe, record the expected selection, and let the sampling edge pass.
  task automatic applyStimulus(input logic [6:0] base, input logic [6:0] addr,
                               input logic [3:0] rs, input logic [3:0] we);
    exp_t e;
    baseSPIAddr    = base;
    currentSPIAddr = addr;
    address_strobe = 1'b1;
    e.rs = rs;
    e.we = we;
    sbQ.push_back(e);
    tick();
  endtask

  task automatic checkSelect(input string name);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({name, "_read_select"}, 32'(read_select), 32'(e.rs));
      checkOutput({name, "_write_enable"}, 32'(write_enable), 32'(e.we));
      miso_local = e.rs;
      MISOin     = 1'b0;
      #1;
      checkOutput({name, "_miso_a"}, 32'(MISOout), 32'(e.rs != 4'b0000));
      miso_local = ~e.rs;
      MISOin     = 1'b1;
      #1;
      checkOutput({name, "_miso_b"}, 32'(MISOout), 32'(e.rs == 4'b0000));
      miso_local = '0;
      MISOin     = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{7'h10, 7'h12, 1'b1, 4'b0100, 4'b0100};
    vecs[1]  = '{7'h10, 7'h7F, 1'b1, 4'b0000, 4'b1111};
    vecs[2]  = '{7'h10, 7'h14, 1'b1, 4'b0000, 4'b0000};
    vecs[3]  = '{7'h10, 7'h10, 1'b1, 4'b0001, 4'b0001};
    vecs[4]  = '{7'h10, 7'h13, 1'b1, 4'b1000, 4'b1000};
    vecs[5]  = '{7'h10, 7'h0F, 1'b1, 4'b0000, 4'b0000};
    vecs[6]  = '{7'h10, 7'h11, 1'b1, 4'b0010, 4'b0010};
    vecs[7]  = '{7'h10, 7'h11, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{7'h7E, 7'h00, 1'b1, 4'b0100, 4'b0100};
    vecs[9]  = '{7'h7E, 7'h7F, 1'b1, 4'b0000, 4'b1111};
    vecs[10] = '{7'h7E, 7'h7E, 1'b1, 4'b0001, 4'b0001};
    vecs[11] = '{7'h7E, 7'h02, 1'b1, 4'b0000, 4'b0000};
    vecs[12] = '{7'h7E, 7'h01, 1'b1, 4'b1000, 4'b1000};

    // Reset hold and release
    #2 RSTin = 1'b0;
    #1;
    checkOutput("rst_local_async_assert", 32'(rst_local), 32'd1);
    repeat (5) tick();
    checkOutput("reset_rst_local", 32'(rst_local), 32'd1);
    checkOutput("reset_read_select", 32'(read_select), 32'd0);
    checkOutput("reset_write_enable", 32'(write_enable), 32'd0);
    checkOutput("reset_irqout", 32'(IRQout), 32'd0);
    checkOutput("reset_rstout", 32'(RSTout), 32'd0);
    RSTin = 1'b1;
    #1;
    checkOutput("rstout_follow", 32'(RSTout), 32'd1);
    tick();
    checkOutput("rst_local_edge1", 32'(rst_local), 32'd1);
    tick();
    checkOutput("rst_local_edge2", 32'(rst_local), 32'd0);

    // Pass-through
    for (int p = 0; p < 4; p++) begin
      SCLKin = p[0];
      MOSIin = p[1];
      #1;
      checkOutput("sclkout", 32'(SCLKout), 32'(p[0]));
      checkOutput("sclk_local", 32'(sclk_local), 32'(p[0]));
      checkOutput("mosiout", 32'(MOSIout), 32'(p[1]));
      checkOutput("mosi_local", 32'(mosi_local), 32'(p[1]));
    end
    checkOutput("scsnout", 32'(SCSNout), 32'd0);
    checkOutput("scsn_local", 32'(scsn_local), 32'd0);
    tick();

    // Table-driven decode
    for (int i = 0; i < 13; i++) begin
      if (ID_in !== vecs[i].idIn) begin
        ID_in = vecs[i].idIn;
        repeat (3) tick();
      end
      applyStimulus(vecs[i].base, vecs[i].addr, vecs[i].expRead, vecs[i].expWrite);
      address_strobe = 1'b0;
      checkSelect($sformatf("vec%0d", i));
    end

    // Back-to-back strobes: last one wins
    applyStimulus(7'h10, 7'h12, 4'b0100, 4'b0100);
    checkSelect("b2b_first");
    applyStimulus(7'h10, 7'h13, 4'b1000, 4'b1000);
    address_strobe = 1'b0;
    checkSelect("b2b_second");

    // Chip-select release returns to IDLE after SYNC_STAGES+1 edges
    applyStimulus(7'h10, 7'h11, 4'b0010, 4'b0010);
    address_strobe = 1'b0;
    checkSelect("scsn_select");
    SCSNin = 1'b1;
    tick();
    checkOutput("scsn_hold_edge1", 32'(read_select), 32'h2);
    tick();
    checkOutput("scsn_hold_edge2", 32'(read_select), 32'h2);
    tick();
    checkOutput("scsn_release_rs", 32'(read_select), 32'h0);
    checkOutput("scsn_release_we", 32'(write_enable), 32'h0);
    SCSNin = 1'b0;
    repeat (3) tick();
    applyStimulus(7'h10, 7'h11, 4'b0010, 4'b0010);
    address_strobe = 1'b0;
    checkSelect("scsn_reselect");
    SCSNin = 1'b1;
    tick();
    tick();
    applyStimulus(7'h10, 7'h13, 4'b1000, 4'b1000);
    address_strobe = 1'b0;
    checkSelect("scsn_strobe_wins");
    tick();
    checkOutput("scsn_strobe_kept", 32'(read_select), 32'h8);
    SCSNin = 1'b0;
    repeat (3) tick();

    // Downstream interrupt through its synchroniser
    IRQ_in = 1'b1;
    tick();
    checkOutput("irq_in_edge1", 32'(IRQout), 32'd0);
    tick();
    checkOutput("irq_in_edge2", 32'(IRQout), 32'd1);
    IRQ_in = 1'b0;
    repeat (2) tick();
    checkOutput("irq_in_clear", 32'(IRQout), 32'd0);

`ifdef SPI_ROUTER_IRQ_LATCH_EN
    applyStimulus(7'h10, 7'h11, 4'b0010, 4'b0010);
    address_strobe = 1'b0;
    checkSelect("latch_sel_t1");
    irq_local = 4'b0001;
    tick();
    irq_local = 4'b0000;
    #1;
    checkOutput("latch_set", 32'(IRQout), 32'd1);
    repeat (2) tick();
    checkOutput("latch_hold", 32'(IRQout), 32'd1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checkOutput("latch_clear_not_owner", 32'(IRQout), 32'd1);
    applyStimulus(7'h10, 7'h10, 4'b0001, 4'b0001);
    address_strobe = 1'b0;
    checkSelect("latch_sel_t0");
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checkOutput("latch_cleared", 32'(IRQout), 32'd0);
    irq_local = 4'b0001;
    tick();
    irq_local = 4'b0000;
    tick();
    irq_local = 4'b0001;
    irq_clear = 1'b1;
    tick();
    irq_local = 4'b0000;
    irq_clear = 1'b0;
    #1;
    checkOutput("latch_set_beats_clear", 32'(IRQout), 32'd1);
`else
    irq_local = 4'b0010;
    #1;
    checkOutput("irq_local_level", 32'(IRQout), 32'd1);
    irq_local = 4'b0000;
    #1;
    checkOutput("irq_local_drop", 32'(IRQout), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/spi_chain_router.md
# spi_chain_router

Parametrised successor to the single-target SPI pass-through in the miner daisy chain. Forwards the SPI bus and reset to the next chip, and serves up to NUM_LOCAL local register targets at consecutive chain addresses starting at baseSPIAddr. Selection is per-target for unicast and all-target for broadcast, and it is released automatically at end of transaction. Downstream and local interrupts are merged onto IRQout.

## Interface
- ADDR_W, 7, chain address width
- NUM_LOCAL, 1, number of local targets (1..8)
- SYNC_STAGES, 2, flops per synchroniser (>=2)
- SPI_CLK  in  1  sole clock
- RSTin  in  1  asynchronous, active-low reset; also forwarded
- ID_in  in  1  chip-enable from chain, async, synchronised internally
- IRQ_in  in  1  downstream interrupt, async, synchronised internally
- address_strobe  in  1  one-cycle pulse; currentSPIAddr valid this cycle
- currentSPIAddr  in  ADDR_W  address decoded by SPI front end
- baseSPIAddr  in  ADDR_W  address of local target 0
- irq_clear  in  1  one-cycle pulse from register write (used only with latch macro)
- SCLKin, SCSNin, MOSIin  in  1 each  upstream bus
- MISOout  out  1  upstream read data
- sclk_local, scsn_local, mosi_local  out  1 each  copies of upstream bus
- miso_local  in  NUM_LOCAL  per-target read data
- irq_local  in  NUM_LOCAL  per-target interrupt, SPI_CLK domain
- read_select  out  NUM_LOCAL  one-hot (or zero) read owner
- write_enable  out  NUM_LOCAL  per-target write mask
- rst_local  out  1  active-high reset for local logic
- RSTout, SCLKout, SCSNout, MOSIout  out  1 each  downstream bus
- MISOin  in  1  downstream read data
- IRQout  out  1  merged interrupt

## Operation
- Pass-through: RSTout=RSTin, SCLKout=sclk_local=SCLKin, SCSNout=scsn_local=SCSNin, MOSIout=mosi_local=MOSIin. All purely combinational.
- Reset: rst_local asserts asynchronously when RSTin goes low. It deasserts SYNC_STAGES SPI_CLK edges after RSTin rises. All internal flops reset asynchronously on RSTin low.
- id_active: ID_in after SYNC_STAGES synchroniser.
- Decode: offset = (currentSPIAddr − baseSPIAddr) mod 2^ADDR_W.
  - unicast hit k: offset==k, k<NUM_LOCAL, and currentSPIAddr != all-ones.
  - broadcast: currentSPIAddr == all-ones. A target whose address wraps onto all-ones is reachable only by broadcast.
- State machine IDLE / UNICAST / BCAST, evaluated on each address_strobe:
  - id_active & unicast hit k -> UNICAST: read_select=write_enable=1<<k.
  - id_active & broadcast -> BCAST: read_select=0, write_enable=all ones.
  - otherwise -> IDLE: both zero.
  - Without a strobe, state holds.
- End of transaction: a rising edge of synchronised SCSNin moves any state to IDLE. If a strobe arrives in the same cycle, the strobe wins.
- MISOout = miso_local[k] when read_select[k]; MISOin when read_select==0.
- IRQout = irq_sync | OR(irq_src), where irq_src is per Configuration.

## Timing
- Reset values: read_select=0, write_enable=0, state=IDLE, synchronisers=0, pending=0. With RSTin low: IRQout=irq_local OR (no macro), or 0 (macro). rst_local=1.
- address_strobe at edge N -> selects valid after edge N+1. Strobes while id_active=0 clear selection.
- ID_in and IRQ_in: SYNC_STAGES cycles latency. SCSN release: SYNC_STAGES+1 cycles.
- Back-to-back strobes: each one re-evaluates; the last one wins.

## Configuration
- SPI_ROUTER_IRQ_LATCH_EN defined:
  - pending[k] sets on the registered rising edge of irq_local[k].
  - pending[k] clears on irq_clear & write_enable[k]. Set wins over a simultaneous clear.
  - irq_src = pending.
- Undefined: irq_src = irq_local (level, combinational), irq_clear ignored, no pending flops.

## Structure
- Shared defines header: state encodings (IDLE=0, UNICAST=1, BCAST=2) and the broadcast-address rule (all-ones of ADDR_W).
- Sub-module spi_sync_bit (parameter SYNC_STAGES, async active-low reset). Instantiated for ID_in, IRQ_in and SCSNin. The reset synchroniser is a variant with asynchronous assertion.

## Test plan
- Reset hold: RSTin low 5 cycles -> rst_local=1 immediately, outputs 0. RSTin high -> rst_local=0 after exactly 2 edges.
- Unicast, ADDR_W=7, NUM_LOCAL=4, base=0x10, ID_in=1, strobe addr 0x12 -> read_select=write_enable=4'b0100. MISOout follows miso_local[2].
- Broadcast addr 0x7F -> write_enable=4'b1111, read_select=0, MISOout follows MISOin. Addr 0x14 -> all zero.
- Wrap: base=0x7E, NUM_LOCAL=3. Addr 0x00 selects target 2; addr 0x7F is broadcast, not target 1.
- SCSN release: select target 1, raise SCSNin -> IDLE 3 cycles later. Strobe coincident with the detected edge -> strobe's selection kept.
- IRQ with SPI_ROUTER_IRQ_LATCH_EN: 1-cycle irq_local[0] pulse -> IRQout latched. irq_clear without write_enable[0] -> stays. With write_enable[0] -> clears. New edge in the clear cycle -> stays set.
